// File: rtl/alu_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_sched_if
// Brief    : RS request, EU issue/result and CDB handshake bundle for the ALU
//            issue scheduler. The master modport is the scheduler side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_sched_if #(
    parameter int RS_DEPTH   = 8,
    parameter int XLEN       = 64,
    parameter int EU_CTL_LEN = 4,
    parameter int EXCEPT_LEN = 2
);
    localparam int IDXW = $clog2(RS_DEPTH);

    logic                             flush_i;
    logic [RS_DEPTH-1:0]              req_valid_i;
    logic [RS_DEPTH*EU_CTL_LEN-1:0]   req_ctl_i;
    logic [RS_DEPTH*XLEN-1:0]         req_rs1_i;
    logic [RS_DEPTH*XLEN-1:0]         req_rs2_i;
    logic [RS_DEPTH-1:0]              issue_ack_o;
    logic                             eu_valid_o;
    logic                             eu_ready_i;
    logic [EU_CTL_LEN-1:0]            eu_ctl_o;
    logic [XLEN-1:0]                  eu_rs1_o;
    logic [XLEN-1:0]                  eu_rs2_o;
    logic [IDXW-1:0]                  eu_entry_idx_o;
    logic                             eu_valid_i;
    logic                             eu_ready_o;
    logic [IDXW-1:0]                  eu_entry_idx_i;
    logic [XLEN-1:0]                  eu_result_i;
    logic                             eu_except_raised_i;
    logic [EXCEPT_LEN-1:0]            eu_except_code_i;
    logic                             cdb_valid_o;
    logic                             cdb_ready_i;
    logic [IDXW-1:0]                  cdb_idx_o;
    logic [XLEN-1:0]                  cdb_result_o;
    logic                             cdb_except_raised_o;
    logic [EXCEPT_LEN-1:0]            cdb_except_code_o;
    logic                             busy_o;

    modport master (
        input  flush_i, req_valid_i, req_ctl_i, req_rs1_i, req_rs2_i,
        output issue_ack_o,
        output eu_valid_o, eu_ctl_o, eu_rs1_o, eu_rs2_o, eu_entry_idx_o,
        input  eu_ready_i,
        input  eu_valid_i, eu_entry_idx_i, eu_result_i, eu_except_raised_i,
        input  eu_except_code_i,
        output eu_ready_o,
        output cdb_valid_o, cdb_idx_o, cdb_result_o, cdb_except_raised_o,
        output cdb_except_code_o,
        input  cdb_ready_i,
        output busy_o
    );

    modport slave (
        output flush_i, req_valid_i, req_ctl_i, req_rs1_i, req_rs2_i,
        input  issue_ack_o,
        input  eu_valid_o, eu_ctl_o, eu_rs1_o, eu_rs2_o, eu_entry_idx_o,
        output eu_ready_i,
        output eu_valid_i, eu_entry_idx_i, eu_result_i, eu_except_raised_i,
        output eu_except_code_i,
        input  eu_ready_o,
        input  cdb_valid_o, cdb_idx_o, cdb_result_o, cdb_except_raised_o,
        input  cdb_except_code_o,
        output cdb_ready_i,
        input  busy_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_sched
// Brief    : Round-robin issue scheduler for a single non-pipelined ALU; one op
//            in flight, result held on the CDB until accepted.
//            Optional watchdog on the EU result: ALU_ISSUE_SCHED_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_sched #(
    parameter int RS_DEPTH   = 8,
    parameter int XLEN       = 64,
    parameter int EU_CTL_LEN = 4,
    parameter int EXCEPT_LEN = 2,
    parameter int MAX_WAIT   = 15
) (
    input  wire               clk_i,
    input  wire               rst_n_i,
    alu_issue_sched_if.master bus
);

    localparam int                    IDXW                = $clog2(RS_DEPTH);
    localparam logic [IDXW-1:0]       c_RR_RESET          = IDXW'(RS_DEPTH - 1);
    localparam logic [EXCEPT_LEN-1:0] c_CODE_TAG_MISMATCH = '1;

    generate
        if ((RS_DEPTH < 2) || ((RS_DEPTH & (RS_DEPTH - 1)) != 0)) begin : g_bad_rs_depth
            $error("alu_issue_sched: RS_DEPTH must be a power of 2 and >= 2");
        end
        if (MAX_WAIT < 1) begin : g_bad_max_wait
            $error("alu_issue_sched: MAX_WAIT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDXW-1:0]       r_rr_ptr;
    logic [IDXW-1:0]       w_grant_idx;
    logic                  w_grant_found;
    logic                  w_grant;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_tag_mismatch;
    logic [RS_DEPTH-1:0]   w_issue_ack;

    logic [EU_CTL_LEN-1:0] r_eu_ctl;
    logic [XLEN-1:0]       r_eu_rs1;
    logic [XLEN-1:0]       r_eu_rs2;
    logic [IDXW-1:0]       r_eu_idx;

    logic [IDXW-1:0]       r_cdb_idx;
    logic [XLEN-1:0]       r_cdb_result;
    logic                  r_cdb_raised;
    logic [EXCEPT_LEN-1:0] r_cdb_code;

    // Scan downward so the entry closest after r_rr_ptr is the last (winning)
    // assignment; offset RS_DEPTH wraps to r_rr_ptr itself, searched last.
    always_comb begin
        logic [IDXW-1:0] w_cand;
        w_cand        = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int i = RS_DEPTH; i >= 1; i--) begin
            w_cand = r_rr_ptr + IDXW'(i);
            if (bus.req_valid_i[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    assign w_grant        = (r_state == ST_IDLE) && w_grant_found && !bus.flush_i;
    assign w_capture      = (r_state == ST_WAIT) && bus.eu_valid_i && !bus.flush_i;
    assign w_tag_mismatch = (bus.eu_entry_idx_i != r_eu_idx);

    always_comb begin
        w_issue_ack = '0;
        if (w_grant) begin
            w_issue_ack[w_grant_idx] = 1'b1;
        end
    end

`ifdef ALU_ISSUE_SCHED_WATCHDOG_EN
    localparam int                     c_WDW          = $clog2(MAX_WAIT + 1);
    localparam logic [c_WDW-1:0]       c_WD_LAST      = c_WDW'(MAX_WAIT - 1);
    localparam logic [EXCEPT_LEN-1:0]  c_CODE_TIMEOUT = EXCEPT_LEN'(2'b10);

    logic [c_WDW-1:0] r_wd_cnt;

    // Counter holds the number of completed WAIT cycles; the edge that would
    // take it to MAX_WAIT is the timeout edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wd_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_WDW'(1);
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !bus.eu_valid_i && !bus.flush_i
                     && (r_wd_cnt == c_WD_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_found)             w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.eu_ready_i)            w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.eu_valid_i || w_timeout) w_state_nxt = ST_WB;
            ST_WB:    if (bus.cdb_ready_i)           w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rr_ptr <= c_RR_RESET;
            r_eu_ctl <= '0;
            r_eu_rs1 <= '0;
            r_eu_rs2 <= '0;
            r_eu_idx <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_grant_idx;
            r_eu_ctl <= bus.req_ctl_i[w_grant_idx*EU_CTL_LEN +: EU_CTL_LEN];
            r_eu_rs1 <= bus.req_rs1_i[w_grant_idx*XLEN +: XLEN];
            r_eu_rs2 <= bus.req_rs2_i[w_grant_idx*XLEN +: XLEN];
            r_eu_idx <= w_grant_idx;
        end
    end

    // A returned tag that disagrees with the issued entry is reported as an
    // exception, but the result is still delivered to the issued entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cdb_idx    <= '0;
            r_cdb_result <= '0;
            r_cdb_raised <= 1'b0;
            r_cdb_code   <= '0;
        end else if (w_capture) begin
            r_cdb_idx    <= r_eu_idx;
            r_cdb_result <= bus.eu_result_i;
            if (w_tag_mismatch) begin
                r_cdb_raised <= 1'b1;
                r_cdb_code   <= c_CODE_TAG_MISMATCH;
            end else begin
                r_cdb_raised <= bus.eu_except_raised_i;
                r_cdb_code   <= bus.eu_except_code_i;
            end
`ifdef ALU_ISSUE_SCHED_WATCHDOG_EN
        end else if (w_timeout) begin
            r_cdb_idx    <= r_eu_idx;
            r_cdb_result <= '0;
            r_cdb_raised <= 1'b1;
            r_cdb_code   <= c_CODE_TIMEOUT;
`endif
        end
    end

    assign bus.issue_ack_o         = w_issue_ack;
    assign bus.eu_valid_o          = (r_state == ST_ISSUE);
    assign bus.eu_ctl_o            = r_eu_ctl;
    assign bus.eu_rs1_o            = r_eu_rs1;
    assign bus.eu_rs2_o            = r_eu_rs2;
    assign bus.eu_entry_idx_o      = r_eu_idx;
    assign bus.eu_ready_o          = (r_state == ST_WAIT);
    assign bus.cdb_valid_o         = (r_state == ST_WB);
    assign bus.cdb_idx_o           = r_cdb_idx;
    assign bus.cdb_result_o        = r_cdb_result;
    assign bus.cdb_except_raised_o = r_cdb_raised;
    assign bus.cdb_except_code_o   = r_cdb_code;
    assign bus.busy_o              = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_sched
// Brief    : Self-checking bench for alu_issue_sched: vector table, corner
//            sequences and randomized ops against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_sched;

    localparam int RS_DEPTH   = 8;
    localparam int XLEN       = 64;
    localparam int EU_CTL_LEN = 4;
    localparam int EXCEPT_LEN = 2;
    localparam int MAX_WAIT   = 15;
    localparam int IDXW       = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_issue_sched_if #(
        .RS_DEPTH  (RS_DEPTH),
        .XLEN      (XLEN),
        .EU_CTL_LEN(EU_CTL_LEN),
        .EXCEPT_LEN(EXCEPT_LEN)
    ) bus ();

    alu_issue_sched #(
        .RS_DEPTH  (RS_DEPTH),
        .XLEN      (XLEN),
        .EU_CTL_LEN(EU_CTL_LEN),
        .EXCEPT_LEN(EXCEPT_LEN),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: last granted entry and last result on the CDB.
    int              model_rr;
    logic [XLEN-1:0] model_last_res;

    typedef struct {
        logic [RS_DEPTH-1:0] req;
        int                  exp_g;
        int                  eu_dly;
        int                  ret_dly;
        int                  cdb_dly;
        bit                  mism;
        int                  flush_at;   // 0 none, 1 ISSUE, 2 WAIT, 3 WB, 4 IDLE
        bit                  fixed;      // entry gets ADD 5,7
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [RS_DEPTH-1:0] req);
        for (int k = 1; k <= RS_DEPTH; k++) begin
            int e;
            e = (model_rr + k) % RS_DEPTH;
            if (req[e]) return e;
        end
        return -1;
    endfunction

    // Caller is at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic do_op(input logic [RS_DEPTH-1:0] req, input int exp_g,
                         input int eu_dly, input int ret_dly, input int cdb_dly,
                         input bit mism, input int flush_at, input bit fixed);
        logic [RS_DEPTH*EU_CTL_LEN-1:0] ctl_v;
        logic [RS_DEPTH*XLEN-1:0]       rs1_v, rs2_v;
        logic [EU_CTL_LEN-1:0]          e_ctl;
        logic [XLEN-1:0]                e_rs1, e_rs2, res;
        logic                           eu_raised, e_raised;
        logic [EXCEPT_LEN-1:0]          eu_code, e_code;
        int                             tag;

        for (int k = 0; k < RS_DEPTH; k++) begin
            ctl_v[k*EU_CTL_LEN +: EU_CTL_LEN] = EU_CTL_LEN'($urandom);
            rs1_v[k*XLEN +: XLEN]             = {$urandom, $urandom};
            rs2_v[k*XLEN +: XLEN]             = {$urandom, $urandom};
        end
        if (fixed && exp_g >= 0) begin
            ctl_v[exp_g*EU_CTL_LEN +: EU_CTL_LEN] = '0;
            rs1_v[exp_g*XLEN +: XLEN]             = 64'd5;
            rs2_v[exp_g*XLEN +: XLEN]             = 64'd7;
        end
        bus.req_ctl_i   = ctl_v;
        bus.req_rs1_i   = rs1_v;
        bus.req_rs2_i   = rs2_v;
        bus.req_valid_i = req;
        bus.flush_i     = (flush_at == 4);
        #1;
        check("issue_ack", bus.issue_ack_o,
              (exp_g < 0 || flush_at == 4) ? 64'd0 : (64'd1 << exp_g));
        check("idle_busy", bus.busy_o, 0);
        if (exp_g < 0 || flush_at == 4) begin
            @(negedge clk);
            bus.flush_i = 1'b0;
            check("stay_idle", bus.busy_o, 0);
            return;
        end

        e_ctl    = ctl_v[exp_g*EU_CTL_LEN +: EU_CTL_LEN];
        e_rs1    = rs1_v[exp_g*XLEN +: XLEN];
        e_rs2    = rs2_v[exp_g*XLEN +: XLEN];
        res      = (e_ctl == '0) ? e_rs1 + e_rs2 : e_rs1 ^ e_rs2;
        model_rr = exp_g;

        @(negedge clk);
        check("ack_is_pulse", bus.issue_ack_o, 0);
        check("eu_valid",     bus.eu_valid_o, 1);
        check("eu_ctl",       bus.eu_ctl_o, e_ctl);
        check("eu_rs1",       bus.eu_rs1_o, e_rs1);
        check("eu_rs2",       bus.eu_rs2_o, e_rs2);
        check("eu_idx",       bus.eu_entry_idx_o, exp_g);
        if (flush_at == 1) begin
            bus.flush_i = 1'b1;
            @(negedge clk);
            bus.flush_i = 1'b0;
            check("flush_issue_busy",  bus.busy_o, 0);
            check("flush_issue_valid", bus.eu_valid_o, 0);
            return;
        end
        repeat (eu_dly) begin
            @(negedge clk);
            check("eu_hold_valid", bus.eu_valid_o, 1);
            check("eu_hold_rs1",   bus.eu_rs1_o, e_rs1);
        end
        bus.eu_ready_i = 1'b1;
        @(negedge clk);
        bus.eu_ready_i = 1'b0;
        check("eu_valid_drop", bus.eu_valid_o, 0);
        check("eu_ready_o",    bus.eu_ready_o, 1);
        if (flush_at == 2) begin
            bus.flush_i        = 1'b1;
            bus.eu_valid_i     = 1'b1;
            bus.eu_result_i    = {$urandom, $urandom};
            bus.eu_entry_idx_i = IDXW'(exp_g);
            @(negedge clk);
            bus.flush_i    = 1'b0;
            bus.eu_valid_i = 1'b0;
            check("flush_wait_busy",   bus.busy_o, 0);
            check("flush_wait_cdbv",   bus.cdb_valid_o, 0);
            check("flush_wait_nowr",   bus.cdb_result_o, model_last_res);
            return;
        end
        repeat (ret_dly) begin
            @(negedge clk);
            check("wait_ready", bus.eu_ready_o, 1);
            check("wait_cdbv",  bus.cdb_valid_o, 0);
        end
        eu_raised = fixed ? 1'b0 : 1'($urandom);
        eu_code   = EXCEPT_LEN'($urandom);
        tag       = mism ? (exp_g + 6) % RS_DEPTH : exp_g;
        e_raised  = mism ? 1'b1 : eu_raised;
        e_code    = mism ? '1 : eu_code;
        bus.eu_valid_i         = 1'b1;
        bus.eu_result_i        = res;
        bus.eu_entry_idx_i     = IDXW'(tag);
        bus.eu_except_raised_i = eu_raised;
        bus.eu_except_code_i   = eu_code;
        @(negedge clk);
        bus.eu_valid_i = 1'b0;
        model_last_res = res;
        check("cdb_valid",  bus.cdb_valid_o, 1);
        check("ready_drop", bus.eu_ready_o, 0);
        check("cdb_idx",    bus.cdb_idx_o, exp_g);
        check("cdb_result", bus.cdb_result_o, res);
        check("cdb_raised", bus.cdb_except_raised_o, e_raised);
        check("cdb_code",   bus.cdb_except_code_o, e_code);
        if (fixed) check("add_result", bus.cdb_result_o, 64'd12);
        if (flush_at == 3) begin
            bus.flush_i = 1'b1;
            @(negedge clk);
            bus.flush_i = 1'b0;
            check("flush_wb_busy", bus.busy_o, 0);
            check("flush_wb_cdbv", bus.cdb_valid_o, 0);
            return;
        end
        repeat (cdb_dly) begin
            @(negedge clk);
            check("cdb_hold_valid",  bus.cdb_valid_o, 1);
            check("cdb_hold_result", bus.cdb_result_o, res);
        end
        bus.cdb_ready_i = 1'b1;
        @(negedge clk);
        bus.cdb_ready_i = 1'b0;
        check("cdb_done_valid", bus.cdb_valid_o, 0);
        check("cdb_done_busy",  bus.busy_o, 0);
    endtask

    // Issue one op whose result never comes back.
    task automatic no_response(input logic [RS_DEPTH-1:0] req);
        int g;
        g = model_pick(req);
        bus.req_valid_i = req;
        #1;
        check("nr_ack", bus.issue_ack_o, 64'd1 << g);
        model_rr = g;
        @(negedge clk);
        bus.eu_ready_i = 1'b1;
        @(negedge clk);
        bus.eu_ready_i = 1'b0;
        check("nr_wait", bus.eu_ready_o, 1);
`ifdef ALU_ISSUE_SCHED_WATCHDOG_EN
        repeat (MAX_WAIT - 1) @(negedge clk);
        check("wd_not_yet", bus.cdb_valid_o, 0);
        @(negedge clk);
        check("wd_cdbv",   bus.cdb_valid_o, 1);
        check("wd_result", bus.cdb_result_o, 0);
        check("wd_raised", bus.cdb_except_raised_o, 1);
        check("wd_code",   bus.cdb_except_code_o, 2'b10);
        check("wd_idx",    bus.cdb_idx_o, g);
        model_last_res  = '0;
        bus.cdb_ready_i = 1'b1;
        @(negedge clk);
        bus.cdb_ready_i = 1'b0;
        check("wd_done", bus.busy_o, 0);
`else
        repeat (100) @(negedge clk);
        check("nr_busy_stuck", bus.busy_o, 1);
        check("nr_no_cdb",     bus.cdb_valid_o, 0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("nr_flush_idle", bus.busy_o, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.flush_i            = 1'b0;
        bus.req_valid_i        = '0;
        bus.req_ctl_i          = '0;
        bus.req_rs1_i          = '0;
        bus.req_rs2_i          = '0;
        bus.eu_ready_i         = 1'b0;
        bus.eu_valid_i         = 1'b0;
        bus.eu_entry_idx_i     = '0;
        bus.eu_result_i        = '0;
        bus.eu_except_raised_i = 1'b0;
        bus.eu_except_code_i   = '0;
        bus.cdb_ready_i        = 1'b0;
        model_rr               = RS_DEPTH - 1;
        model_last_res         = '0;

        //          req    g  eu ret cdb mism flush fixed
        tbl[0]  = '{8'h83, 0, 0, 0,  0,  1'b0, 0, 1'b0};
        tbl[1]  = '{8'h83, 1, 4, 1,  3,  1'b0, 0, 1'b0};
        tbl[2]  = '{8'h83, 7, 0, 0,  0,  1'b0, 0, 1'b0};
        tbl[3]  = '{8'h83, 0, 1, 2,  1,  1'b0, 0, 1'b0};
        tbl[4]  = '{8'h04, 2, 0, 1,  0,  1'b0, 0, 1'b1};
        tbl[5]  = '{8'h20, 5, 0, 0,  0,  1'b1, 0, 1'b0};
        tbl[6]  = '{8'h20, 5, 0, 0,  0,  1'b0, 0, 1'b0};
        tbl[7]  = '{8'h00, -1, 0, 0, 0,  1'b0, 0, 1'b0};
        tbl[8]  = '{8'h83, 7, 0, 0,  0,  1'b0, 1, 1'b0};
        tbl[9]  = '{8'h83, 0, 0, 0,  0,  1'b0, 2, 1'b0};
        tbl[10] = '{8'h83, 1, 0, 0,  0,  1'b0, 3, 1'b0};
        tbl[11] = '{8'h83, 7, 0, 0,  0,  1'b0, 4, 1'b0};
        tbl[12] = '{8'h83, 7, 0, 1,  0,  1'b0, 0, 1'b0};
        tbl[13] = '{8'h0C, 2, 0, 0,  0,  1'b0, 0, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_busy",      bus.busy_o, 0);
        check("rst_eu_valid",  bus.eu_valid_o, 0);
        check("rst_eu_ready",  bus.eu_ready_o, 0);
        check("rst_cdb_valid", bus.cdb_valid_o, 0);
        check("rst_ack",       bus.issue_ack_o, 0);
        check("rst_cdb_res",   bus.cdb_result_o, 0);
        check("rst_eu_rs1",    bus.eu_rs1_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].req, tbl[i].exp_g, tbl[i].eu_dly, tbl[i].ret_dly,
                  tbl[i].cdb_dly, tbl[i].mism, tbl[i].flush_at, tbl[i].fixed);
        end

        no_response(8'h08);

        // Asynchronous reset in the middle of an issue.
        bus.req_valid_i = 8'h10;
        #1;
        check("ar_ack", bus.issue_ack_o, 64'd1 << model_pick(8'h10));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy",     bus.busy_o, 0);
        check("ar_eu_valid", bus.eu_valid_o, 0);
        check("ar_eu_rs1",   bus.eu_rs1_o, 0);
        model_rr       = RS_DEPTH - 1;
        model_last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h81, 0, 0, 0, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [RS_DEPTH-1:0] r;
            int                  fa;
            r  = RS_DEPTH'($urandom_range(1, 255));
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op(r, model_pick(r), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0), fa, 1'b0);
        end
        do_op(8'h00, -1, 0, 0, 0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
